// File: rtl/edge_ts_pkg.sv
// Shared definitions for the edge timestamp logger: default parameter
// values and the event record layout used at the default widths.
package edge_ts_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_TS_W   = 32;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_DROP_W = 8;

    // Stages in the optional input synchronizer (EDGE_TS_SYNC_EN builds).
    localparam int SYNC_STAGES = 2;

    typedef logic [DEF_TS_W-1:0] ts_t;

    // One logged event: which bits toggled, the new bus value, and when.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] mask;
        logic [DEF_WIDTH-1:0] data;
        ts_t                  ts;
    } ev_t;

endpackage

// File: rtl/edge_ts_fifo.sv
// Generic DEPTH-entry synchronous FIFO with show-ahead head output.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module edge_ts_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Read/write pointer advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Event storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: storage is reset on purpose: the head is visible on the ports and must read zero after reset.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/edge_ts_logger.sv
// Edge timestamp logger: samples a bus every clock, turns each set of bit
// toggles into one timestamped event, queues events for a valid/ready
// consumer, and counts events dropped while the queue is full.
// Optional build macro EDGE_TS_SYNC_EN adds a 2-flop input synchronizer.
module edge_ts_logger
    import edge_ts_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int TS_W   = DEF_TS_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DROP_W = DEF_DROP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  data_i,
    output logic              ev_valid_o,
    input  logic              ev_ready_i,
    output logic [WIDTH-1:0]  ev_mask_o,
    output logic [WIDTH-1:0]  ev_data_o,
    output logic [TS_W-1:0]   ev_ts_o,
    output logic              overflow_o,
    output logic [DROP_W-1:0] drop_cnt_o
);

    // Event layout at this instance's widths (same field order as edge_ts_pkg::ev_t).
    typedef logic [TS_W-1:0] stamp_t;
    typedef struct packed {
        logic [WIDTH-1:0] mask;
        logic [WIDTH-1:0] data;
        stamp_t           ts;
    } event_t;

    localparam int EV_W = $bits(event_t);

    stamp_t            timer_q;
    logic [WIDTH-1:0]  prev_q;
    logic              primed_q;
    logic [WIDTH-1:0]  sample;
    logic              prime_ok;
    logic [WIDTH-1:0]  mask;
    logic              push;
    logic              pop_fire;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    event_t            push_ev;
    event_t            head_ev;
    logic              overflow_q;
    logic [DROP_W-1:0] drop_cnt_q;

`ifdef EDGE_TS_SYNC_EN
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [1:0]       fill_q;

    // Two-flop synchronizer plus a fill counter so detection waits for real data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            fill_q  <= '0;
        end else begin
            sync1_q <= data_i;
            sync2_q <= sync1_q;
            if (fill_q != 2'(SYNC_STAGES)) fill_q <= fill_q + 2'd1;
        end
    end

    assign sample   = sync2_q;
    assign prime_ok = (fill_q == 2'(SYNC_STAGES));
`else
    assign sample   = data_i;
    assign prime_ok = 1'b1;
`endif

    // Free-running timestamp, previous-sample register and priming flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q  <= '0;
            prev_q   <= '0;
            primed_q <= 1'b0;
        end else begin
            timer_q  <= timer_q + TS_W'(1);
            prev_q   <= sample;
            primed_q <= prime_ok;
        end
    end

    // Toggle detection; nothing is reported until a valid previous sample exists.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        mask = '0;
        if (primed_q) mask = sample ^ prev_q;
    end

    assign push      = |mask;
    assign pop_fire  = ev_ready_i && !fifo_empty;
    assign drop      = push && fifo_full && !pop_fire;
    assign push_ev   = '{mask: mask, data: sample, ts: timer_q};

    edge_ts_fifo #(
        .W     (EV_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_ev),
        .full      (fifo_full),
        .pop       (ev_ready_i),
        .head      (head_ev),
        .empty     (fifo_empty)
    );

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + DROP_W'(1);
        end
    end

    assign ev_valid_o = !fifo_empty;
    assign ev_mask_o  = head_ev.mask;
    assign ev_data_o  = head_ev.data;
    assign ev_ts_o    = head_ev.ts;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_edge_ts_logger.sv
// Scoreboard bench for edge_ts_logger: stimulus pushes expected events,
// monitors pop and compare on every valid/ready handshake.
module tb_edge_ts_logger;
    import edge_ts_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data;
    logic        ready;
    logic        ev_valid;
    logic [7:0]  ev_mask;
    logic [7:0]  ev_data;
    logic [31:0] ev_ts;
    logic        overflow;
    logic [7:0]  drop_cnt;

    logic [7:0]  d2;
    logic        r2;
    logic        ev_valid2;
    logic [7:0]  ev_mask2;
    logic [7:0]  ev_data2;
    logic [3:0]  ev_ts2;
    logic        overflow2;
    logic [7:0]  drop_cnt2;

    int          checks   = 0;
    int          failures = 0;
    int          n_pop1   = 0;
    int          n_pop2   = 0;
    logic [31:0] cyc;
    logic [31:0] last_ts;
    logic        have_last;
    logic [31:0] ts0;

    ev_t         q1[$];
    logic [19:0] q2[$];

    edge_ts_logger dut (
        .clk (clk), .rst (rst), .data_i (data),
        .ev_valid_o (ev_valid), .ev_ready_i (ready),
        .ev_mask_o (ev_mask), .ev_data_o (ev_data), .ev_ts_o (ev_ts),
        .overflow_o (overflow), .drop_cnt_o (drop_cnt)
    );

    edge_ts_logger #(.TS_W(4)) dut_w (
        .clk (clk), .rst (rst), .data_i (d2),
        .ev_valid_o (ev_valid2), .ev_ready_i (r2),
        .ev_mask_o (ev_mask2), .ev_data_o (ev_data2), .ev_ts_o (ev_ts2),
        .overflow_o (overflow2), .drop_cnt_o (drop_cnt2)
    );

    always #5 clk = ~clk;

    // Reference timestamp: edges seen since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= '0;
        else     cyc <= cyc + 32'd1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] hold);
        rst = 1'b1;
        data = hold;
        q1.delete();
        q2.delete();
        have_last = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor for the default-width instance.
    always @(negedge clk) begin
        if (!rst && ev_valid && ready) begin
            check("m1_expected_pending", q1.size() != 0, 1);
            if (q1.size() != 0) begin
                ev_t e;
                e = q1.pop_front();
                check("m1_mask", ev_mask, e.mask);
                check("m1_data", ev_data, e.data);
                check("m1_ts",   ev_ts,   e.ts);
                if (have_last) check("m1_ts_increasing", ev_ts > last_ts, 1);
                last_ts   = ev_ts;
                have_last = 1'b1;
                n_pop1++;
            end
        end
    end

    // Monitor for the narrow-timestamp instance.
    always @(negedge clk) begin
        if (!rst && ev_valid2 && r2) begin
            check("m2_expected_pending", q2.size() != 0, 1);
            if (q2.size() != 0) begin
                logic [19:0] e;
                e = q2.pop_front();
                check("m2_mask", ev_mask2, e[19:12]);
                check("m2_data", ev_data2, e[11:4]);
                check("m2_ts",   ev_ts2,   e[3:0]);
                n_pop2++;
            end
        end
    end

    logic [7:0] vals  [6] = '{8'h0A, 8'h0B, 8'h1B, 8'h9B, 8'h99, 8'h00};
    logic [7:0] masks [6] = '{8'h0F, 8'h01, 8'h10, 8'h80, 8'h02, 8'h99};

    initial begin
        rst = 1'b1; data = 8'hFF; ready = 1'b0; d2 = 8'h00; r2 = 1'b0; have_last = 1'b0;
        #2;
        check("rst_valid",    ev_valid, 0);
        check("rst_mask",     ev_mask,  0);
        check("rst_data",     ev_data,  0);
        check("rst_ts",       ev_ts,    0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Priming with a non-zero bus must not produce an event.
        for (int i = 0; i < 10; i++) begin
            step();
            check("prime_no_event", ev_valid, 0);
        end

        // Single event at timer=5, one cycle latency; empty pops are ignored.
        do_reset(8'h00);
        ready = 1'b1;
        repeat (5) step();
        check("empty_pop_valid", ev_valid, 0);
        data = 8'h05;
        q1.push_back('{mask: 8'h05, data: 8'h05, ts: 32'd5});
        step();
        check("latency_valid", ev_valid, 1);
        step();
        check("popped_valid", ev_valid, 0);
        check("first_event_popped", n_pop1, 1);

        // Six toggles with no consumer: four queued, two dropped.
        ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            data = vals[i];
            if (i == 0) ts0 = cyc;
            if (i < 4) q1.push_back('{mask: masks[i], data: vals[i], ts: cyc});
            step();
        end
        check("ovf_set",      overflow, 1);
        check("drop_cnt_2",   drop_cnt, 2);
        step();
        step();
        check("hold_valid",   ev_valid, 1);
        check("hold_mask",    ev_mask,  8'h0F);
        check("hold_data",    ev_data,  8'h0A);
        check("hold_ts",      ev_ts,    ts0);

        // Full FIFO, push and pop on the same edge: nothing dropped.
        data  = 8'h3C;
        ready = 1'b1;
        q1.push_back('{mask: 8'h3C, data: 8'h3C, ts: cyc});
        step();
        check("fullpp_drop_cnt", drop_cnt, 2);
        check("fullpp_valid",    ev_valid, 1);
        for (int k = 0; k < 20 && q1.size() != 0; k++) step();
        check("drain_done", q1.size(), 0);
        step();
        check("drain_pops", n_pop1, 6);
        check("drain_valid", ev_valid, 0);

        // Saturating drop counter, then asynchronous reset mid-burst.
        do_reset(8'h00);
        ready = 1'b0;
        step();
        for (int i = 0; i < 310; i++) begin
            data = ~data;
            if (i < 4) q1.push_back('{mask: 8'hFF, data: data, ts: cyc});
            step();
            if (i == 103) check("drop_cnt_100", drop_cnt, 100);
        end
        check("drop_cnt_sat", drop_cnt, 255);
        check("sat_overflow", overflow, 1);
        data = ~data;
        step();
        check("sat_hold", drop_cnt, 255);
        rst = 1'b1;
        q1.delete();
        #1;
        check("async_rst_valid",    ev_valid, 0);
        check("async_rst_drop_cnt", drop_cnt, 0);
        check("async_rst_overflow", overflow, 0);
        check("async_rst_ts",       ev_ts,    0);

        // Timestamp wrap on the 4-bit-timer instance.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        r2 = 1'b1;
        repeat (15) step();
        d2 = 8'h01;
        q2.push_back({8'h01, 8'h01, 4'hF});
        step();
        d2 = 8'h03;
        q2.push_back({8'h02, 8'h03, 4'h0});
        step();
        for (int k = 0; k < 20 && q2.size() != 0; k++) step();
        check("wrap_done", q2.size(), 0);
        check("wrap_pops", n_pop2, 2);
        check("wrap_no_drop", drop_cnt2, 0);

        check("final_q1_empty", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
